// File: rtl/fi_pkg.sv
// Shared definitions for the systolic-array fault-injection campaign controller.
//   fi_state_t       : campaign FSM states
//   SA_MODE_*        : encodings of the sa_mode input
//   TMR_SEL_DOUBLE   : tmr_pe_sel value that faults replicas 0 and 1 together
//   fi_bits_per_pe() : width of one PE's fault slice (6 with TMR, 2 without)
package fi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DRAIN,
        ST_DONE
    } fi_state_t;

    localparam logic [1:0] SA_MODE_SA0      = 2'b00;
    localparam logic [1:0] SA_MODE_SA1      = 2'b01;
    localparam logic [1:0] SA_MODE_BOTH     = 2'b10;
    localparam logic [1:0] SA_MODE_BOTH_ALT = 2'b11;  // aliases BOTH

    localparam logic [1:0] TMR_SEL_DOUBLE   = 2'b11;

    function automatic int fi_bits_per_pe(input int tmr_en);
        return (tmr_en != 0) ? 6 : 2;
    endfunction

    // Both polarities are run (SA0 pass first, then SA1).
    function automatic logic sa_mode_is_both(input logic [1:0] mode);
        return (mode == SA_MODE_BOTH) || (mode == SA_MODE_BOTH_ALT);
    endfunction

    // Polarity of the first (or only) pass.
    function automatic logic sa_mode_first_sa(input logic [1:0] mode);
        return (mode != SA_MODE_SA0) && !sa_mode_is_both(mode) && (mode == SA_MODE_SA1);
    endfunction

endpackage

// File: rtl/fi_site_encoder.sv
// Combinational fault-bus encoder.
//   site_idx   : PE index (col*ROWS + row) to fault
//   sa         : stuck-at polarity
//   tmr_pe_sel : replica select (0..2, 3 = replicas 0 and 1); unused without TMR
//   fault_bus  : full fault_inject_bus image; only the selected site's slice is
//                non-zero, and within it only the enabled replica pairs {sa, 1}.
module fi_site_encoder
    import fi_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int TMR_EN = 1,
    parameter int IDX_W  = 2,
    parameter int FI_W   = ROWS * COLS * fi_bits_per_pe(TMR_EN)
) (
    input  logic [IDX_W-1:0] site_idx,
    input  logic             sa,
    input  logic [1:0]       tmr_pe_sel,
    output logic [FI_W-1:0]  fault_bus
);

    localparam int BPP = fi_bits_per_pe(TMR_EN);

    // Slice pattern for whichever site is selected.
    logic [BPP-1:0] slice;

    generate
        if (TMR_EN != 0) begin : g_tmr
            for (genvar gi = 0; gi < 3; gi++) begin : g_rep
                logic rep_en;
                assign rep_en = (tmr_pe_sel == 2'(gi))
                             || ((tmr_pe_sel == TMR_SEL_DOUBLE) && (gi < 2));
                assign slice[2*gi +: 2] = rep_en ? {sa, 1'b1} : 2'b00;
            end
        end else begin : g_plain
            assign slice = {sa, 1'b1};
        end
    endgenerate

    for (genvar gi = 0; gi < ROWS * COLS; gi++) begin : g_site
        assign fault_bus[gi*BPP +: BPP] = (site_idx == IDX_W'(gi)) ? slice : '0;
    end

endmodule

// File: rtl/systolic_fi_campaign_ctrl.sv
// BIST fault-injection campaign controller for traditional/TMR systolic arrays.
// Walks a stuck-at fault over every PE site (row fastest), for one or both
// polarities, comparing DUT and golden bottom outputs after a settle delay and
// recording per-site mismatch maps.
//   clk, rst             : clock, synchronous active-high reset
//   start, abort         : begin campaign (IDLE only) / stop immediately
//   sa_mode, tmr_pe_sel  : polarity mode and replica select, latched at start
//   dut/gold_bottom_out_bus : compared outputs
//   fault_inject_bus     : registered fault drive
//   busy, done           : campaign running / one-cycle completion pulse
//   cur_row, cur_col     : site under test
//   err_map_sa0/sa1, err_count : results, held until the next accepted start
module systolic_fi_campaign_ctrl
    import fi_pkg::*;
#(
    parameter int ROWS           = 2,
    parameter int COLS           = 2,
    parameter int WORD_SIZE      = 16,
    parameter int TMR_EN         = 1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int COMPARE_CYCLES = 4,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         abort,
    input  logic [1:0]                                   sa_mode,
    input  logic [1:0]                                   tmr_pe_sel,
    input  logic [COLS*WORD_SIZE-1:0]                    dut_bottom_out_bus,
    input  logic [COLS*WORD_SIZE-1:0]                    gold_bottom_out_bus,
    output logic [ROWS*COLS*fi_bits_per_pe(TMR_EN)-1:0]  fault_inject_bus,
    output logic                                         busy,
    output logic                                         done,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]   cur_row,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]   cur_col,
    output logic [ROWS*COLS-1:0]                         err_map_sa0,
    output logic [ROWS*COLS-1:0]                         err_map_sa1,
    output logic [$clog2(2*ROWS*COLS+1)-1:0]             err_count
);

    localparam int N       = ROWS * COLS;
    localparam int FI_W    = N * fi_bits_per_pe(TMR_EN);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int ERR_W   = $clog2(2 * N + 1);
    localparam int CNT_MAX = (SETTLE_CYCLES > COMPARE_CYCLES)
                           ? ((SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES)
                           : ((COMPARE_CYCLES > DRAIN_CYCLES) ? COMPARE_CYCLES : DRAIN_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COMPARE_LAST = CNT_W'(COMPARE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

    fi_state_t         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [COL_W-1:0]  col_reg;
    logic              sa_reg;
    logic              both_reg;
    logic [1:0]        tmr_sel_reg;
    logic              sticky_reg;
    logic [FI_W-1:0]   fault_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [N-1:0]      map0_reg;
    logic [N-1:0]      map1_reg;
    logic [ERR_W-1:0]  err_count_reg;

    // "Upcoming" site: the site the next SETTLE entry will use. In IDLE it is
    // the campaign's first site; in DRAIN it is the advanced site. The encoder
    // runs on it so the fault register loads on the same edge as the state.
    logic [ROW_W-1:0]  upc_row;
    logic [COL_W-1:0]  upc_col;
    logic              upc_sa;
    logic [1:0]        upc_sel;
    logic              campaign_end;
    logic              last_site;
    logic [IDX_W-1:0]  upc_idx;
    logic [IDX_W-1:0]  cur_idx;
    logic [FI_W-1:0]   enc_bus;
    logic              hit;

    always_comb begin
        upc_row      = row_reg;
        upc_col      = col_reg;
        upc_sa       = sa_reg;
        upc_sel      = tmr_sel_reg;
        campaign_end = 1'b0;
        last_site    = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
        if (state_reg == ST_IDLE) begin
            upc_row = '0;
            upc_col = '0;
            upc_sa  = sa_mode_first_sa(sa_mode);
            upc_sel = tmr_pe_sel;
        end else if (last_site) begin
            if (!sa_reg && both_reg) begin
                upc_row = '0;
                upc_col = '0;
                upc_sa  = 1'b1;
            end else begin
                campaign_end = 1'b1;
            end
        end else if (row_reg == ROW_LAST) begin
            upc_row = '0;
            upc_col = col_reg + 1'b1;
        end else begin
            upc_row = row_reg + 1'b1;
        end
    end

    assign upc_idx = IDX_W'(upc_col) * IDX_W'(ROWS) + IDX_W'(upc_row);
    assign cur_idx = IDX_W'(col_reg) * IDX_W'(ROWS) + IDX_W'(row_reg);

    // The final compare cycle's own sample is folded in directly.
    assign hit = sticky_reg | (dut_bottom_out_bus != gold_bottom_out_bus);

    fi_site_encoder #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .TMR_EN (TMR_EN),
        .IDX_W  (IDX_W),
        .FI_W   (FI_W)
    ) u_encoder (
        .site_idx   (upc_idx),
        .sa         (upc_sa),
        .tmr_pe_sel (upc_sel),
        .fault_bus  (enc_bus)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            sa_reg        <= 1'b0;
            both_reg      <= 1'b0;
            tmr_sel_reg   <= '0;
            sticky_reg    <= 1'b0;
            fault_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            map0_reg      <= '0;
            map1_reg      <= '0;
            err_count_reg <= '0;
        end else if (abort && (state_reg != ST_IDLE)) begin
            // Partial maps and the current site are deliberately kept.
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            sticky_reg <= 1'b0;
            fault_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_reg     <= ST_SETTLE;
                        cnt_reg       <= '0;
                        row_reg       <= upc_row;
                        col_reg       <= upc_col;
                        sa_reg        <= upc_sa;
                        both_reg      <= sa_mode_is_both(sa_mode);
                        tmr_sel_reg   <= tmr_pe_sel;
                        sticky_reg    <= 1'b0;
                        fault_reg     <= enc_bus;
                        busy_reg      <= 1'b1;
                        map0_reg      <= '0;
                        map1_reg      <= '0;
                        err_count_reg <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_COMPARE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (cnt_reg == COMPARE_LAST) begin
                        if (sa_reg) begin
                            map1_reg[cur_idx] <= hit;
                        end else begin
                            map0_reg[cur_idx] <= hit;
                        end
                        err_count_reg <= err_count_reg + ERR_W'(hit);
                        sticky_reg    <= 1'b0;
                        fault_reg     <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= ST_DRAIN;
                    end else begin
                        sticky_reg <= hit;
                        cnt_reg    <= cnt_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_reg == DRAIN_LAST) begin
                        cnt_reg <= '0;
                        if (campaign_end) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            row_reg   <= upc_row;
                            col_reg   <= upc_col;
                            sa_reg    <= upc_sa;
                            fault_reg <= enc_bus;
                            state_reg <= ST_SETTLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign fault_inject_bus = fault_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign cur_row          = row_reg;
    assign cur_col          = col_reg;
    assign err_map_sa0      = map0_reg;
    assign err_map_sa1      = map1_reg;
    assign err_count        = err_count_reg;

endmodule

// File: tb/tb_systolic_fi_campaign_ctrl.sv
// Self-checking bench for systolic_fi_campaign_ctrl (2x2, TMR, S=C=D=4).
// A schedule model derives every output from the cycle count since the
// accepted start; a faulty-array stand-in corrupts the DUT bus whenever an
// active fault slice matches a chosen (site, polarity) set.
module tb_systolic_fi_campaign_ctrl;

    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int WS   = 16;
    localparam int S    = 4;
    localparam int C    = 4;
    localparam int D    = 4;
    localparam int N    = ROWS * COLS;
    localparam int L    = S + C + D;
    localparam int FI_W = N * 6;
    localparam int BUSW = COLS * WS;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [1:0]      sa_mode = 2'b00;
    logic [1:0]      tmr_pe_sel = 2'b00;
    logic [BUSW-1:0] gold_bus = '0;
    logic [BUSW-1:0] dut_bus;
    logic [FI_W-1:0] fault_inject_bus;
    logic            busy;
    logic            done;
    logic            cur_row;
    logic            cur_col;
    logic [N-1:0]    err_map_sa0;
    logic [N-1:0]    err_map_sa1;
    logic [3:0]      err_count;

    // Which (polarity, site) pairs make the faulty array misbehave.
    logic [N-1:0]    corrupt_sa0 = '0;
    logic [N-1:0]    corrupt_sa1 = '0;
    logic            corrupt_now;
    logic [5:0]      slice;
    logic            slice_sa;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    systolic_fi_campaign_ctrl #(
        .ROWS (ROWS), .COLS (COLS), .WORD_SIZE (WS), .TMR_EN (1),
        .SETTLE_CYCLES (S), .COMPARE_CYCLES (C), .DRAIN_CYCLES (D)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .abort (abort),
        .sa_mode (sa_mode), .tmr_pe_sel (tmr_pe_sel),
        .dut_bottom_out_bus (dut_bus), .gold_bottom_out_bus (gold_bus),
        .fault_inject_bus (fault_inject_bus), .busy (busy), .done (done),
        .cur_row (cur_row), .cur_col (cur_col),
        .err_map_sa0 (err_map_sa0), .err_map_sa1 (err_map_sa1),
        .err_count (err_count)
    );

    // Faulty-array stand-in: reacts to whatever fault the controller drives.
    always_comb begin
        corrupt_now = 1'b0;
        slice       = '0;
        slice_sa    = 1'b0;
        for (int i = 0; i < N; i++) begin
            slice    = fault_inject_bus[i*6 +: 6];
            slice_sa = (slice[0] & slice[1]) | (slice[2] & slice[3]) | (slice[4] & slice[5]);
            if (slice[0] | slice[2] | slice[4]) begin
                if (slice_sa ? corrupt_sa1[i] : corrupt_sa0[i]) corrupt_now = 1'b1;
            end
        end
    end
    assign dut_bus = gold_bus ^ (corrupt_now ? 32'h0001_0000 : 32'h0);

    // Input sampling at the active edge.
    logic       s_rst, s_start, s_abort;
    logic [1:0] s_mode, s_sel;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        gold_bus <= $urandom;
        s_rst    <= rst;
        s_start  <= start;
        s_abort  <= abort;
        s_mode   <= sa_mode;
        s_sel    <= tmr_pe_sel;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [FI_W-1:0] enc(input int idx, input logic sa, input logic [1:0] sel);
        logic [FI_W-1:0] v;
        v = '0;
        for (int k = 0; k < 3; k++) begin
            if (int'(sel) == k || (sel == 2'd3 && k < 2)) begin
                v[idx*6 + 2*k]     = 1'b1;
                v[idx*6 + 2*k + 1] = sa;
            end
        end
        return v;
    endfunction

    // Model state
    bit         m_active = 0;
    int         m_j = 0;
    int         m_p = 1;
    logic       m_sa0 = 0;
    logic [1:0] m_sel = 0;
    logic [N-1:0] m_map0 = '0;
    logic [N-1:0] m_map1 = '0;
    int         m_idx = 0;
    int         done_pulses = 0;
    int         done_label = 0;
    int         busy_cnt = 0;

    always @(negedge clk) begin
        int t, step, pos, pass_sa;
        logic exp_busy, exp_done;
        logic [FI_W-1:0] exp_fault;
        if (cyc > 0) begin
            if (s_rst) begin
                m_active = 0; m_j = 0; m_map0 = '0; m_map1 = '0; m_idx = 0;
            end else if (m_active && s_abort) begin
                m_active = 0;
            end else if (!m_active && s_start && !s_abort) begin
                m_active = 1; m_j = 0;
                m_p   = s_mode[1] ? 2 : 1;
                m_sa0 = s_mode[1] ? 1'b0 : s_mode[0];
                m_sel = s_sel;
                m_map0 = '0; m_map1 = '0; m_idx = 0;
            end else if (m_active) begin
                m_j++;
                if (m_j > m_p * N * L) m_active = 0;
            end
            t = m_p * N * L;
            exp_busy  = m_active && (m_j < t);
            exp_done  = m_active && (m_j == t);
            exp_fault = '0;
            if (exp_busy) begin
                step    = m_j / L;
                pos     = m_j % L;
                m_idx   = step % N;
                pass_sa = (m_p == 2) ? (step / N) : int'(m_sa0);
                if (pos < S + C) exp_fault = enc(m_idx, pass_sa[0], m_sel);
                if (pos == S + C) begin
                    if (pass_sa == 1 && corrupt_sa1[m_idx]) m_map1[m_idx] = 1'b1;
                    if (pass_sa == 0 && corrupt_sa0[m_idx]) m_map0[m_idx] = 1'b1;
                end
            end
            check("fault_bus", fault_inject_bus, exp_fault);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("cur_row", cur_row, m_idx % ROWS);
            check("cur_col", cur_col, m_idx / ROWS);
            check("map_sa0", err_map_sa0, m_map0);
            check("map_sa1", err_map_sa1, m_map1);
            check("err_count", err_count, $countones(m_map0) + $countones(m_map1));
            if (done === 1'b1) begin
                done_pulses++;
                done_label = cyc + 1;
            end
            if (busy === 1'b1) busy_cnt++;
        end
    end

    int t0;
    int k;
    int tl;
    int act;
    int p0;
    logic [1:0] r_mode, r_sel;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_campaign(input logic [1:0] mode, input logic [1:0] sel);
        sa_mode    = mode;
        tmr_pe_sel = sel;
        busy_cnt   = 0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        t0         = cyc;
    endtask

    task automatic wait_done();
        int p;
        p = done_pulses;
        for (int i = 0; i < 300 && done_pulses == p; i++) tick();
        check("done_timeout", done_pulses != p, 1);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_fault", fault_inject_bus, 0);
        check("rst_busy", busy, 0);
        check("rst_count", err_count, 0);

        // Clean array, SA1 only
        start_campaign(2'b01, 2'd0);
        wait_done();
        check("t1_done_cycle", done_label - t0, 49);
        check("t1_busy_cycles", busy_cnt, 48);
        check("t1_map0", err_map_sa0, 0);
        check("t1_map1", err_map_sa1, 0);
        check("t1_count", err_count, 0);

        // Site 2 fails under SA1
        corrupt_sa1 = 4'b0100;
        start_campaign(2'b01, 2'd0);
        wait_done();
        check("t2_map1", err_map_sa1, 4'b0100);
        check("t2_count", err_count, 1);

        // Both polarities, site 3 fails under SA0
        corrupt_sa1 = 4'b0000;
        corrupt_sa0 = 4'b1000;
        start_campaign(2'b10, 2'd1);
        wait_done();
        check("t3_done_cycle", done_label - t0, 97);
        check("t3_map0", err_map_sa0, 4'b1000);
        check("t3_map1", err_map_sa1, 0);
        corrupt_sa0 = 4'b0000;

        // Encoding: replica 2 SA0 at site 2, then double fault SA1
        start_campaign(2'b00, 2'd2);
        repeat (2 * L) tick();
        check("t4_enc_sel2", fault_inject_bus, 24'h010000);
        abort = 1'b1; tick(); abort = 1'b0;
        start_campaign(2'b01, 2'd3);
        repeat (2 * L) tick();
        check("t4_enc_sel3", fault_inject_bus, 24'h00F000);
        abort = 1'b1; tick(); abort = 1'b0;

        // Abort during compare of site 1
        corrupt_sa1 = 4'b0001;
        start_campaign(2'b01, 2'd0);
        repeat (L + S + 1) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("t5_fault", fault_inject_bus, 0);
        check("t5_busy", busy, 0);
        check("t5_map1", err_map_sa1, 4'b0001);
        p0 = done_pulses;
        repeat (60) tick();
        check("t5_no_done", done_pulses, p0);
        start_campaign(2'b01, 2'd0);
        check("t5_cleared", err_map_sa1, 0);
        wait_done();

        // Abort beats start in IDLE
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        check("abort_wins", busy, 0);

        // Start while busy is ignored
        start_campaign(2'b01, 2'd0);
        tick(); start = 1'b1; tick(); start = 1'b0;
        wait_done();
        check("t6_done_cycle", done_label - t0, 49);

        // Reset during settle of site 2
        start_campaign(2'b01, 2'd0);
        repeat (2 * L + 1) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_rst_fault", fault_inject_bus, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_col", cur_col, 0);
        check("t6_rst_map1", err_map_sa1, 0);
        check("t6_rst_count", err_count, 0);

        // Randomised campaigns
        for (int r = 0; r < 14; r++) begin
            r_mode      = 2'($urandom_range(0, 3));
            r_sel       = 2'($urandom_range(0, 3));
            corrupt_sa0 = 4'($urandom);
            corrupt_sa1 = 4'($urandom);
            start_campaign(r_mode, r_sel);
            tl  = (r_mode[1] ? 2 : 1) * N * L;
            act = $urandom_range(0, 3);
            if (act == 0) begin
                k = $urandom_range(0, tl);
                repeat (k) tick();
                abort = 1'b1; start = 1'($urandom_range(0, 1));
                tick();
                abort = 1'b0; start = 1'b0;
            end else if (act == 1) begin
                repeat ($urandom_range(1, 30)) tick();
                start = 1'b1; tick(); start = 1'b0;
                wait_done();
            end else if (act == 2) begin
                repeat ($urandom_range(0, tl)) tick();
                rst = 1'b1; tick(); rst = 1'b0;
            end else begin
                wait_done();
            end
            repeat ($urandom_range(1, 5)) tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/systolic_fi_campaign_ctrl.md
Name: systolic_fi_campaign_ctrl

Overview:
- Synthesizable fault-injection campaign controller for the traditional/TMR systolic arrays.
- Steps a stuck-at fault through every PE site, and through every selected replica when TMR is enabled. For each site it drives fault_inject_bus, waits for the fault to propagate, then compares DUT and golden bottom_out_bus over a window.
- Records a per-site error map for one or both stuck-at polarities.
- Sits beside a DUT array and a fault-free checker array as the BIST engine.

Parameters:
- ROWS, 2, array rows.
- COLS, 2, array columns.
- WORD_SIZE, 16, data word width.
- TMR_EN, 1, 1 = 6 fault bits per PE (three replicas); 0 = 2 bits per PE.
- SETTLE_CYCLES, 4, cycles from fault applied to first compare; must be ≥1.
- COMPARE_CYCLES, 4, compare window length; must be ≥1.
- DRAIN_CYCLES, 4, fault-free cycles between sites; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin campaign; sampled only in IDLE.
- abort  in  1  end campaign immediately.
- sa_mode  in  2  00 stuck-at-0; 01 stuck-at-1; 10 both (SA0 pass, then SA1 pass); 11 treated as 10.
- tmr_pe_sel  in  2  replica to fault (0..2); 3 = replicas 0 and 1 together (double fault). Ignored when TMR_EN=0.
- dut_bottom_out_bus  in  COLS*WORD_SIZE  DUT outputs.
- gold_bottom_out_bus  in  COLS*WORD_SIZE  checker outputs.
- fault_inject_bus  out  ROWS*COLS*(TMR_EN?6:2)  registered fault drive.
- busy  out  1  campaign in progress.
- done  out  1  one-cycle pulse at normal completion.
- cur_row  out  max(1,$clog2(ROWS))  site under test.
- cur_col  out  max(1,$clog2(COLS))  site under test.
- err_map_sa0  out  ROWS*COLS  bit idx=1: mismatch seen with SA0 at site idx.
- err_map_sa1  out  ROWS*COLS  same, for SA1.
- err_count  out  $clog2(2*ROWS*COLS+1)  total set bits across both maps.

Behaviour:
- Reset: all outputs 0; FSM in IDLE. Reset asserted mid-campaign takes effect at the next edge, so fault_inject_bus is 0 from the following cycle.
- Site order: idx = col*ROWS + row, with row varying fastest (idx 0..ROWS*COLS-1).
- Fault encoding:
  - Non-TMR: bits [idx*2+1 : idx*2] = {sa, 1}.
  - TMR: 6-bit slice at idx*6. Replica k occupies bits [2k+1 : 2k] = {sa, en_k}.
  - Every other slice, and every non-enabled pair, is all-zero.
- FSM states: IDLE, SETTLE, COMPARE, DRAIN, DONE.
- IDLE:
  - On start with abort=0: clear both maps, err_count and the sticky bit; set site=0 and pass=first polarity; go to SETTLE.
  - busy=1 from the next cycle.
- SETTLE: fault slice driven for the current site. Stay SETTLE_CYCLES cycles, then go to COMPARE.
- COMPARE:
  - Each cycle: sticky |= (dut_bottom_out_bus != gold_bottom_out_bus).
  - After COMPARE_CYCLES cycles, write the sticky value into the current pass's map bit, increment err_count if set, clear sticky, go to DRAIN.
- DRAIN:
  - fault_inject_bus=0 for DRAIN_CYCLES cycles.
  - Then advance: next site → SETTLE. After the last site of an SA0 pass in mode both → SA1 pass, site 0. Otherwise → DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. Maps and count hold until the next accepted start.
- Timing: start accepted at edge t0.
  - Fault visible at t0+1.
  - Compares at t0+1+S … t0+S+C.
  - done high in cycle t0 + P·N·(S+C+D) + 1, where N=ROWS*COLS and P = passes (1 or 2).
- abort: in any non-IDLE state, next cycle → IDLE. fault_inject_bus=0, busy=0, done stays 0. Partial maps are retained. abort wins over start.
- start while busy is ignored. cur_row/cur_col hold their last values in IDLE.

Decomposition:
- Package fi_pkg:
  - State enum.
  - FI_BITS_PER_PE(TMR_EN) function.
  - sa_mode encodings.
- Sub-module fi_site_encoder (combinational): maps idx, sa and tmr_pe_sel to the full fault_inject_bus. The controller registers its output.

Test Plan (ROWS=COLS=2, WORD_SIZE=16, S=C=D=4, TMR_EN=1; bench model corrupts DUT output only while a chosen fault slice is active):
1. dut tied to gold, sa_mode=01, start at t0 → done at t0+49; both maps 0; err_count=0; busy high t0+1..t0+48.
2. Model corrupts when site 2 (row0,col1) has SA1, sa_mode=01 → err_map_sa1=4'b0100, err_count=1.
3. sa_mode=10, model corrupts only on site 3 with SA0 → err_map_sa0=4'b1000, err_map_sa1=0, done at t0+97.
4. Encoding checks:
   - tmr_pe_sel=2, SA0, site 2 in SETTLE → fault_inject_bus[17:12]=6'b010000, all other bits 0.
   - tmr_pe_sel=3, SA1 → 6'b001111.
5. abort in COMPARE of site 1 → next cycle fault_inject_bus=0, busy=0; done never pulses; err_map bit 0 retained. A new start clears the maps.
6. rst during SETTLE of site 2 → next cycle all outputs 0. start pulse while busy (SETTLE) → ignored, schedule unchanged.
